// File: rtl/enigma_char_sequencer.sv
// Sequences received ASCII bytes through an Enigma cipher core and queues results for a UART.
// Letter: rotate 1 cycle after accept, capture at 2+SETTLE_CYCLES; passthrough bytes queue in the same cycle.
// Backpressure: 1-entry pending register, FIFO stalls on tx_busy, lost bytes set overrun. Option: SEQ_GROUP5_EN.
module enigma_char_sequencer #(
    parameter int FIFO_DEPTH    = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       i_clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] sm_data,
    output logic       sm_rotate,
    input  logic [7:0] sm_result,
    input  logic       sm_valid,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       busy,
    output logic       overrun
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ROTATE,
        SETTLE,
        CAPTURE
`ifdef SEQ_GROUP5_EN
        , GROUP
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        pend_vld, pend_vld_nxt;
    logic [7:0]  pend_dat, pend_dat_nxt;
    logic        load_sm;
    logic        push;
    logic [7:0]  push_dat;
    logic        ovr_set;
    logic        pop;
    logic        can_push;
    logic        full, empty;
    logic        cand_vld;
    logic [7:0]  cand_dat;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [7:0]  mem [FIFO_DEPTH];
`ifdef SEQ_GROUP5_EN
    logic [2:0]  grp_cnt, grp_cnt_nxt;
`endif

    function automatic logic is_letter(input logic [7:0] b);
        return ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A));
    endfunction

    function automatic logic is_pass(input logic [7:0] b);
        return (b == 8'h20) || (b == 8'h0D) || (b == 8'h0A);
    endfunction

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign pop      = !empty && !tx_busy && !tx_start;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign can_push = !full || pop;
    assign cand_vld = pend_vld || rx_valid;
    assign cand_dat = pend_vld ? pend_dat : rx_data;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pend_vld_nxt = pend_vld;
        pend_dat_nxt = pend_dat;
        load_sm      = 1'b0;
        push         = 1'b0;
        push_dat     = 8'h00;
        ovr_set      = 1'b0;
`ifdef SEQ_GROUP5_EN
        grp_cnt_nxt  = grp_cnt;
`endif
        if (state == IDLE) begin
            // Pending byte wins; a same-cycle arrival refills the slot it vacates.
            if (pend_vld) begin
                pend_vld_nxt = rx_valid;
                pend_dat_nxt = rx_valid ? rx_data : pend_dat;
            end
        end else if (rx_valid) begin
            if (pend_vld) begin
                ovr_set = 1'b1;
            end else begin
                pend_vld_nxt = 1'b1;
                pend_dat_nxt = rx_data;
            end
        end

        case (state)
            IDLE: begin
                if (cand_vld) begin
                    if (is_letter(cand_dat)) begin
                        load_sm   = 1'b1;
                        state_nxt = ROTATE;
                    end else if (is_pass(cand_dat)) begin
                        push     = can_push;
                        push_dat = cand_dat;
                        ovr_set  = ovr_set || !can_push;
                    end
                end
            end
            ROTATE: begin
                cnt_nxt   = 4'd0;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt == 4'(SETTLE_CYCLES - 1)) begin
                    state_nxt = CAPTURE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            CAPTURE: begin
                state_nxt = IDLE;
                if (sm_valid) begin
                    if (can_push) begin
                        push     = 1'b1;
                        push_dat = sm_result;
`ifdef SEQ_GROUP5_EN
                        if (grp_cnt == 3'd4) begin
                            grp_cnt_nxt = 3'd0;
                            state_nxt   = GROUP;
                        end else begin
                            grp_cnt_nxt = grp_cnt + 3'd1;
                        end
`endif
                    end else begin
                        ovr_set = 1'b1;
                    end
                end
            end
`ifdef SEQ_GROUP5_EN
            GROUP: begin
                if (can_push) begin
                    push      = 1'b1;
                    push_dat  = 8'h20;
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            pend_vld  <= 1'b0;
            pend_dat  <= 8'h00;
            sm_data   <= 8'h00;
            sm_rotate <= 1'b0;
            overrun   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
`ifdef SEQ_GROUP5_EN
            grp_cnt   <= 3'd0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pend_vld  <= pend_vld_nxt;
            pend_dat  <= pend_dat_nxt;
            sm_rotate <= (state_nxt == ROTATE);
            overrun   <= overrun || ovr_set;
            tx_start  <= pop;
            if (load_sm) sm_data <= cand_dat;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tx_data <= mem[rd_ptr[AW-1:0]];
            end
`ifdef SEQ_GROUP5_EN
            grp_cnt   <= grp_cnt_nxt;
`endif
        end
    end

    always_ff @(posedge i_clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// File: doc/enigma_char_sequencer.md
ENIGMA_CHAR_SEQUENCER -- requirements
Module: enigma_char_sequencer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, output FIFO entries; the value SHALL be a power of two, 2..64.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 2, cycles between rotate pulse and result capture; the value SHALL be 1..15.
REQ-003 The block SHALL have port i_clock, in, 1, the single clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port reset, in, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port rx_data, in, 8, received ASCII byte.
REQ-006 The block SHALL have port rx_valid, in, 1, one-cycle strobe qualifying rx_data.
REQ-007 The block SHALL have port sm_data, out, 8, byte presented to the cipher core's i_inputData, registered and held.
REQ-008 The block SHALL have port sm_rotate, out, 1, one-cycle step pulse to the cipher core's rotate input.
REQ-009 The block SHALL have port sm_result, in, 8, cipher core o_outputData.
REQ-010 The block SHALL have port sm_valid, in, 1, cipher core o_valid.
REQ-011 The block SHALL have port tx_data, out, 8, byte to the UART transmitter.
REQ-012 The block SHALL have port tx_start, out, 1, one-cycle send strobe.
REQ-013 The block SHALL have port tx_busy, in, 1, transmitter busy.
REQ-014 The block SHALL have port busy, out, 1, high whenever the FSM is not in IDLE.
REQ-015 The block SHALL have port overrun, out, 1, sticky flag set when a byte is lost.

Function
REQ-016 The FSM SHALL use states IDLE, ROTATE, SETTLE, CAPTURE and GROUP; GROUP SHALL exist only when the REQ-029 macro is defined.
REQ-017 A byte arriving while not IDLE SHALL go to a 1-entry pending register; an arrival while pending is full SHALL drop that byte and set overrun.
REQ-018 In IDLE, the pending byte SHALL take priority over a same-cycle rx_valid; the byte not taken SHALL go to pending.
REQ-019 Bytes 0x41-0x5A and 0x61-0x7A SHALL be classed as letters; 0x20, 0x0D and 0x0A SHALL be classed as passthrough; all other bytes SHALL be discarded in IDLE with no rotate.
REQ-020 For a passthrough byte in IDLE, the block SHALL push the byte unchanged into the FIFO and stay in IDLE; a full FIFO SHALL drop the byte and set overrun.
REQ-021 For a letter accepted in IDLE at cycle 0, the block SHALL load sm_data at cycle 1 and pulse sm_rotate at cycle 1 (ROTATE), then spend exactly SETTLE_CYCLES cycles in SETTLE, then one cycle in CAPTURE at cycle 2+SETTLE_CYCLES.
REQ-022 In CAPTURE, if sm_valid=1 the block SHALL push sm_result into the FIFO; if the FIFO is full it SHALL drop the result and set overrun; if sm_valid=0 it SHALL discard silently; the next state SHALL be IDLE, or GROUP per REQ-029.
REQ-023 sm_rotate SHALL never be high for two consecutive cycles and SHALL never be high outside ROTATE.
REQ-024 The FIFO SHALL use binary pointers one bit wider than log2(FIFO_DEPTH) that wrap modulo 2*FIFO_DEPTH; the FIFO is full when the MSBs differ and the remaining bits are equal, and empty when the pointers are equal; a simultaneous push and pop when full SHALL be legal.
REQ-025 The drain SHALL pop when the FIFO is non-empty, tx_busy=0 and tx_start was low in the previous cycle; a pop SHALL register tx_data and pulse tx_start for 1 cycle.
REQ-026 tx_data SHALL hold its value until the next pop.

Reset
REQ-027 While reset=0, the FSM SHALL be IDLE, the FIFO pointers, pending valid, settle counter and group counter SHALL be 0, sm_data=0x00, sm_rotate=0, tx_data=0x00, tx_start=0, busy=0 and overrun=0.
REQ-028 Reset asserted mid-sequence SHALL abort the sequence with no rotate pulse and no FIFO write on the reset edge; FIFO contents SHALL be discarded.

Configuration
REQ-029 With SEQ_GROUP5_EN defined, the block SHALL count pushed ciphertext letters modulo 5; after the 5th push, CAPTURE SHALL go to GROUP, which SHALL push 0x20, waiting in GROUP while the FIFO is full, and then go to IDLE.
REQ-030 Without SEQ_GROUP5_EN, the GROUP state and the group counter SHALL be absent, and CAPTURE SHALL always return to IDLE.

Verification
REQ-031 The bench SHALL check: rx 0x41 in IDLE with SETTLE_CYCLES=2 -> sm_data=0x41 and sm_rotate=1 at cycle 1, capture at cycle 4, tx_start once with tx_data equal to sm_result.
REQ-032 The bench SHALL check: rx 0x20, then 0x31 -> 0x20 transmitted unchanged and 0x31 dropped; no sm_rotate pulses for either byte.
REQ-033 The bench SHALL check: three letters on consecutive cycles -> first processed, second pending, third dropped; overrun=1; exactly two sm_rotate pulses.
REQ-034 The bench SHALL check: tx_busy held high while 9 letters are processed with FIFO_DEPTH=8 -> 8 entries stored, 9th dropped, overrun=1; releasing tx_busy drains 8 bytes in order.
REQ-035 The bench SHALL check: SEQ_GROUP5_EN defined, 10 letters -> transmitted stream is 5 cipher letters, 0x20, 5 cipher letters, 0x20.
REQ-036 The bench SHALL check: reset=0 during SETTLE -> busy=0, no capture, FIFO empty, and a following letter is processed normally.
